led_bank_arbiter: RTL and testbench
===================================

# led_bank_arbiter

Round-robin arbiter and display scheduler that shares the board's 8-LED bank between up to `N_REQ` requesting blocks. A granted requester's 8-bit pattern is latched and driven onto the LEDs for a programmed number of prescaled ticks, then the bank is released to the next requester. The block sits between the top-level LED pins and any logic that wants to show status, replacing fixed per-design LED assignments.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TICK_DIV`, 1000000: clk cycles per hold tick, ≥1.
- `HOLD_W`, 8: width of each hold field, in ticks.
- `IDLE_PATTERN`, 8'h00: LED value when no requester owns the bank.

Ports:
- `clk` in 1: board clock. One clock domain.
- `rst` in 1: synchronous, active-high reset.
- `req` in `N_REQ`: per-requester request, level; hold high until `ack`.
- `pattern` in `8*N_REQ`: requester i's pattern at `[8i+7:8i]`.
- `hold` in `HOLD_W*N_REQ`: requester i's display time in ticks, at `[HOLD_W*i +: HOLD_W]`.
- `ack` out `N_REQ`: one-cycle grant pulse; the pattern and hold were captured on the same edge.
- `done` out `N_REQ`: one-cycle pulse when the owner's hold expires.
- `busy` out 1: high while the bank is owned.
- `owner` out `$clog2(N_REQ)`: index of the current or last owner.
- `led` out 8: LED drive, registered.

## Operation
- FSM has two states, `IDLE` and `SHOW`.
- **IDLE:**
  - If any `req` is high at an edge, pick the winner round-robin. The search starts at `last_owner+1` and wraps.
  - On that edge: capture `pattern[winner]` into `led`, and capture `max(hold[winner],1)` into the tick counter.
  - Also on that edge: clear the prescaler, set `owner=winner`, pulse `ack[winner]`, go to `SHOW`.
- **SHOW:**
  - The prescaler counts `0..TICK_DIV-1`. Its wrap is a tick, and each tick decrements the tick counter.
  - On the tick that takes the counter to 0: `led<=IDLE_PATTERN`, pulse `done[owner]`, set `last_owner=owner`, go to `IDLE`.
  - `req`, `pattern` and `hold` are ignored in `SHOW`. A requester's `req` may drop after `ack` without aborting the display.
- `hold=0` is treated as 1 tick.
- A `req` that drops before being granted is a withdrawal. No grant is issued and no state is kept.
- A requester that keeps `req` high after `done` is re-eligible, but the round-robin order serves the others first.
- `busy` is high exactly in `SHOW`.
- **Reset**, including mid-`SHOW`:
  - State `IDLE`, `led=IDLE_PATTERN`, `ack=0`, `done=0`, `busy=0`, `owner=0`.
  - Prescaler and tick counter are 0, and `last_owner=N_REQ-1`, so requester 0 has first priority.
  - No `done` pulse is issued for the aborted display.

## Timing
- Grant latency: `req` high before edge k in `IDLE` gives `ack`, `busy`, `owner` and `led` updated in the cycle after edge k, all together.
- The pattern is shown for exactly `max(hold,1)*TICK_DIV` cycles.
- `done` is asserted in the first cycle after the display, coincident with `led=IDLE_PATTERN` and `busy=0`.
- There is always exactly one `IDLE` cycle between consecutive grants, with `IDLE_PATTERN` shown during it. Back-to-back period is `max(hold,1)*TICK_DIV+1` cycles.
- Prescaler width is `$clog2(TICK_DIV+1)`. Tick counter width is `HOLD_W`. No overflow is possible: the prescaler wraps at `TICK_DIV-1`, and the tick counter only decrements from ≥1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Package `led_pkg`:** `LED_W=8`, the FSM state enum (`IDLE`, `SHOW`), and `TICK_DIV_12MHZ=1000000`.
- **Sub-module `led_rr_pick`:** purely combinational round-robin picker. Inputs: `req`, `last_owner`. Outputs: `valid`, `winner`.
- The prescaler, tick counter and FSM live in `led_bank_arbiter`.

## Test plan
All scenarios use `TICK_DIV=4`, `N_REQ=4`.
1. Hold `rst` 3 cycles with random inputs → `led=8'h00`; `ack`, `done`, `busy`, `owner` all 0 throughout and on the first cycle after release.
2. `req[0]`, `pattern0=8'hA5`, `hold0=3` → `ack[0]` one cycle later; `led=8'hA5` for exactly 12 cycles; then `done[0]` with `led=8'h00`.
3. `req[0]` and `req[1]` held continuously, `hold=1` → grants 0,1,0,1, spaced 5 cycles apart, each with a one-cycle `8'h00` gap.
4. `req[2]`, `hold2=0`, `pattern2=8'h3C` → `8'h3C` shown 4 cycles, then `done[2]`.
5. Assert `rst` 6 cycles into a `hold=3` display → `led=8'h00` and `busy=0` next cycle; no `done` pulse; the next grant goes to requester 0.
6. `req[1]` pulsed for 2 cycles during requester 0's `SHOW`, then dropped → `ack[1]` never asserted; bank returns to `IDLE`.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and FSM state type for the LED bank arbiter.
package led_pkg;
    localparam int LED_W          = 8;
    localparam int TICK_DIV_12MHZ = 1000000;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;
endpackage

// File: rtl/led_bank_arbiter_if.sv
// Request/display bus between LED requesters (master) and the bank arbiter (slave).
interface led_bank_arbiter_if
    import led_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int HOLD_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [LED_W*N_REQ-1:0]  pattern;
    logic [HOLD_W*N_REQ-1:0] hold;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        done;
    logic                    busy;
    logic [$clog2(N_REQ)-1:0] owner;
    logic [LED_W-1:0]        led;

    modport master (
        output req, pattern, hold,
        input  ack, done, busy, owner, led
    );

    modport slave (
        input  req, pattern, hold,
        output ack, done, busy, owner, led
    );
endinterface

// File: rtl/led_rr_pick.sv
// Combinational round-robin picker: first active request after last_owner, wrapping.
module led_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);
    always_comb begin
        int cand;
        cand   = 0;
        valid  = 1'b0;
        winner = '0;
        // Offset 1..N_REQ so last_owner itself is considered last.
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(last_owner) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/led_bank_arbiter.sv
// Shares the 8-LED bank between N_REQ requesters, showing each granted pattern for its hold time.
module led_bank_arbiter
    import led_pkg::*;
#(
    parameter int           N_REQ        = 4,
    parameter int           TICK_DIV     = TICK_DIV_12MHZ,
    parameter int           HOLD_W       = 8,
    parameter logic [7:0]   IDLE_PATTERN = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    led_bank_arbiter_if.slave  bus
);
    localparam int IDX_W   = $clog2(N_REQ);
    localparam int PRESC_W = $clog2(TICK_DIV + 1);

    state_t              state_q, state_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_owner_q, last_owner_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [HOLD_W-1:0]   ticks_q, ticks_d;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_winner;
    logic [HOLD_W-1:0]   win_hold;

    led_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (bus.req),
        .last_owner (last_owner_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign win_hold = bus.hold[HOLD_W*int'(pick_winner) +: HOLD_W];

    always_comb begin
        state_d      = state_q;
        led_d        = led_q;
        ack_d        = '0;
        done_d       = '0;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        presc_d      = presc_q;
        ticks_d      = ticks_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    led_d              = bus.pattern[LED_W*int'(pick_winner) +: LED_W];
                    ticks_d            = (win_hold == '0) ? HOLD_W'(1) : win_hold;
                    presc_d            = '0;
                    owner_d            = pick_winner;
                    ack_d[pick_winner] = 1'b1;
                    state_d            = SHOW;
                end
            end
            SHOW: begin
                if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
                    presc_d = '0;
                    ticks_d = ticks_q - HOLD_W'(1);
                    // Final tick: release the bank; counter never goes below zero.
                    if (ticks_q == HOLD_W'(1)) begin
                        led_d           = IDLE_PATTERN;
                        done_d[owner_q] = 1'b1;
                        last_owner_d    = owner_q;
                        state_d         = IDLE;
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            led_q        <= IDLE_PATTERN;
            ack_q        <= '0;
            done_q       <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            presc_q      <= '0;
            ticks_q      <= '0;
        end else begin
            state_q      <= state_d;
            led_q        <= led_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            presc_q      <= presc_d;
            ticks_q      <= ticks_d;
        end
    end

    assign bus.led   = led_q;
    assign bus.ack   = ack_q;
    assign bus.done  = done_q;
    assign bus.owner = owner_q;
    assign bus.busy  = (state_q == SHOW);
endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with TICK_DIV=4, N_REQ=4.
module tb_led_bank_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    led_bank_arbiter_if #(.N_REQ(4), .HOLD_W(8)) bus ();

    led_bank_arbiter #(
        .N_REQ        (4),
        .TICK_DIV     (4),
        .HOLD_W       (8),
        .IDLE_PATTERN (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.req     = 4'($urandom);
            bus.pattern = $urandom;
            bus.hold    = $urandom;
            step();
            checks++;
            if ({bus.led, bus.ack, bus.done, bus.busy, bus.owner} !== 19'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got=%h exp=0", c, {bus.led, bus.ack, bus.done, bus.busy, bus.owner});
            end
        end
        rst     = 1'b0;
        bus.req = '0;
        step();
        checks++;
        if ({bus.led, bus.ack, bus.done, bus.busy, bus.owner} !== 19'd0) begin
            errors++;
            $display("FAIL reset_release got=%h exp=0", {bus.led, bus.ack, bus.done, bus.busy, bus.owner});
        end
    endtask

    task automatic test_single();
        bus.pattern[7:0] = 8'hA5;
        bus.hold[7:0]    = 8'd3;
        bus.req          = 4'b0001;
        step();
        checks++;
        if ({bus.ack, bus.busy, bus.owner, bus.led} !== {4'b0001, 1'b1, 2'd0, 8'hA5}) begin
            errors++;
            $display("FAIL single_grant got=%h exp=%h", {bus.ack, bus.busy, bus.owner, bus.led}, {4'b0001, 1'b1, 2'd0, 8'hA5});
        end
        bus.req = '0;
        for (int c = 2; c <= 12; c++) begin
            step();
            checks++;
            if ({bus.led, bus.busy, bus.done, bus.ack} !== {8'hA5, 1'b1, 4'b0, 4'b0}) begin
                errors++;
                $display("FAIL single_show cyc%0d got=%h exp=%h", c, {bus.led, bus.busy, bus.done, bus.ack}, {8'hA5, 1'b1, 4'b0, 4'b0});
            end
        end
        step();
        checks++;
        if ({bus.done, bus.busy, bus.led} !== {4'b0001, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL single_done got=%h exp=%h", {bus.done, bus.busy, bus.led}, {4'b0001, 1'b0, 8'h00});
        end
    endtask

    task automatic test_alternate();
        logic [7:0] exp_pat;
        int         idx;
        rst     = 1'b1;
        bus.req = '0;
        step();
        rst               = 1'b0;
        bus.pattern[7:0]  = 8'h11;
        bus.pattern[15:8] = 8'h22;
        bus.hold[7:0]     = 8'd1;
        bus.hold[15:8]    = 8'd1;
        bus.req           = 4'b0011;
        for (int g = 0; g < 4; g++) begin
            idx     = g % 2;
            exp_pat = (idx == 0) ? 8'h11 : 8'h22;
            step();
            checks++;
            if ({bus.ack, bus.owner, bus.led, bus.busy} !== {4'(1 << idx), 2'(idx), exp_pat, 1'b1}) begin
                errors++;
                $display("FAIL alt_grant%0d got=%h exp=%h", g, {bus.ack, bus.owner, bus.led, bus.busy}, {4'(1 << idx), 2'(idx), exp_pat, 1'b1});
            end
            for (int c = 0; c < 3; c++) begin
                step();
                checks++;
                if ({bus.led, bus.busy, bus.ack} !== {exp_pat, 1'b1, 4'b0}) begin
                    errors++;
                    $display("FAIL alt_show%0d cyc%0d got=%h exp=%h", g, c, {bus.led, bus.busy, bus.ack}, {exp_pat, 1'b1, 4'b0});
                end
            end
            step();
            checks++;
            if ({bus.done, bus.led, bus.busy, bus.ack} !== {4'(1 << idx), 8'h00, 1'b0, 4'b0}) begin
                errors++;
                $display("FAIL alt_gap%0d got=%h exp=%h", g, {bus.done, bus.led, bus.busy, bus.ack}, {4'(1 << idx), 8'h00, 1'b0, 4'b0});
            end
            if (g == 3) bus.req = '0;
        end
    endtask

    task automatic test_zero_hold();
        bus.pattern[23:16] = 8'h3C;
        bus.hold[23:16]    = 8'd0;
        bus.req            = 4'b0100;
        step();
        checks++;
        if ({bus.ack, bus.owner, bus.led} !== {4'b0100, 2'd2, 8'h3C}) begin
            errors++;
            $display("FAIL zero_grant got=%h exp=%h", {bus.ack, bus.owner, bus.led}, {4'b0100, 2'd2, 8'h3C});
        end
        bus.req = '0;
        for (int c = 2; c <= 4; c++) begin
            step();
            checks++;
            if ({bus.led, bus.busy, bus.done} !== {8'h3C, 1'b1, 4'b0}) begin
                errors++;
                $display("FAIL zero_show cyc%0d got=%h exp=%h", c, {bus.led, bus.busy, bus.done}, {8'h3C, 1'b1, 4'b0});
            end
        end
        step();
        checks++;
        if ({bus.done, bus.led, bus.busy} !== {4'b0100, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL zero_done got=%h exp=%h", {bus.done, bus.led, bus.busy}, {4'b0100, 8'h00, 1'b0});
        end
    endtask

    task automatic test_reset_mid_show();
        bus.pattern[7:0] = 8'h5A;
        bus.hold[7:0]    = 8'd3;
        bus.req          = 4'b0001;
        step();
        checks++;
        if ({bus.ack, bus.led} !== {4'b0001, 8'h5A}) begin
            errors++;
            $display("FAIL rmid_grant got=%h exp=%h", {bus.ack, bus.led}, {4'b0001, 8'h5A});
        end
        bus.req = '0;
        for (int c = 2; c <= 6; c++) step();
        rst = 1'b1;
        step();
        checks++;
        if ({bus.led, bus.busy, bus.done, bus.ack, bus.owner} !== 19'd0) begin
            errors++;
            $display("FAIL rmid_reset got=%h exp=0", {bus.led, bus.busy, bus.done, bus.ack, bus.owner});
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if ({bus.done, bus.busy, bus.led} !== 13'd0) begin
                errors++;
                $display("FAIL rmid_quiet cyc%0d got=%h exp=0", c, {bus.done, bus.busy, bus.led});
            end
        end
        // Requesters 0 and 3 compete: reset priority must favour 0.
        bus.pattern[7:0] = 8'hC3;
        bus.req          = 4'b1001;
        step();
        checks++;
        if ({bus.ack, bus.owner, bus.led} !== {4'b0001, 2'd0, 8'hC3}) begin
            errors++;
            $display("FAIL rmid_regrant got=%h exp=%h", {bus.ack, bus.owner, bus.led}, {4'b0001, 2'd0, 8'hC3});
        end
    endtask

    task automatic test_withdraw();
        bus.req = '0;
        for (int c = 2; c <= 12; c++) begin
            if (c == 3) bus.req = 4'b0010;
            if (c == 5) bus.req = '0;
            step();
            checks++;
            if ({bus.ack, bus.led, bus.busy, bus.done} !== {4'b0, 8'hC3, 1'b1, 4'b0}) begin
                errors++;
                $display("FAIL wd_show cyc%0d got=%h exp=%h", c, {bus.ack, bus.led, bus.busy, bus.done}, {4'b0, 8'hC3, 1'b1, 4'b0});
            end
        end
        step();
        checks++;
        if ({bus.done, bus.ack, bus.led, bus.busy} !== {4'b0001, 4'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL wd_done got=%h exp=%h", {bus.done, bus.ack, bus.led, bus.busy}, {4'b0001, 4'b0, 8'h00, 1'b0});
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({bus.ack, bus.busy, bus.led, bus.done} !== 17'd0) begin
                errors++;
                $display("FAIL wd_idle cyc%0d got=%h exp=0", c, {bus.ack, bus.busy, bus.led, bus.done});
            end
        end
    endtask

    initial begin
        bus.req     = '0;
        bus.pattern = '0;
        bus.hold    = '0;
        test_reset();
        test_single();
        test_alternate();
        test_zero_hold();
        test_reset_mid_show();
        test_withdraw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
